// File: rtl/audio_agc_level_ctrl_if.sv
// Audio AGC sample/level bus.
// master: side that supplies PCM samples and consumes gain/level reports.
// slave : the AGC level controller.
interface audio_agc_level_ctrl_if;
    logic        sample_valid;
    logic [15:0] audio_in;
    logic [2:0]  gain_code;
    logic [15:0] peak_level;
    logic        peak_valid;
    logic        clip_flag;

    modport master (
        output sample_valid,
        output audio_in,
        input  gain_code,
        input  peak_level,
        input  peak_valid,
        input  clip_flag
    );

    modport slave (
        input  sample_valid,
        input  audio_in,
        output gain_code,
        output peak_level,
        output peak_valid,
        output clip_flag
    );
endinterface

// File: rtl/audio_agc_level_ctrl.sv
// Audio automatic gain control.
// Measures the windowed peak |x| of the gain stage output, reports peak and
// clipping once per window, and steps the 3-bit gain code down on loud or
// clipped windows and up after HOLD_WINDOWS consecutive quiet windows.
// Optional build macro AGC_MANUAL_OVERRIDE_EN adds manual_en/manual_code,
// which force the gain code while still reporting levels.
module audio_agc_level_ctrl #(
    parameter int unsigned WINDOW_LOG2  = 10,
    parameter logic [15:0] HI_THRESH    = 16'h6000,
    parameter logic [15:0] LO_THRESH    = 16'h2000,
    parameter int unsigned HOLD_WINDOWS = 4,
    parameter logic [2:0]  INIT_GAIN    = 3'b100
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef AGC_MANUAL_OVERRIDE_EN
    input  logic                    manual_en,
    input  logic [2:0]              manual_code,
`endif
    audio_agc_level_ctrl_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_MEASURE = 1'b0,
        ST_EVAL    = 1'b1
    } state_t;

    localparam logic [WINDOW_LOG2-1:0] CNT_ONE  = WINDOW_LOG2'(1);
    localparam logic [WINDOW_LOG2-1:0] CNT_ZERO = WINDOW_LOG2'(0);
    localparam logic [3:0]             HOLD_Q   = 4'(HOLD_WINDOWS);

    // Saturating absolute value: -32768 maps to 32767 so the result fits 16 bits.
    function automatic logic [15:0] abs_sat(input logic [15:0] x);
        logic [15:0] r;
        if (x == 16'h8000) begin
            r = 16'h7FFF;
        end else if (x[15]) begin
            r = (~x) + 16'd1;
        end else begin
            r = x;
        end
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
    logic [15:0]            run_peak_q, run_peak_d;
    logic                   run_clip_q, run_clip_d;
    logic [15:0]            snap_peak_q, snap_peak_d;
    logic                   snap_clip_q, snap_clip_d;
    logic [3:0]             quiet_q, quiet_d;
    logic [2:0]             gain_q, gain_d;
    logic [15:0]            peak_level_q, peak_level_d;
    logic                   peak_valid_q, peak_valid_d;
    logic                   clip_q, clip_d;

    logic [15:0]            sample_abs_s;
    logic [15:0]            peak_merge_s;
    logic                   clip_merge_s;
    logic                   win_last_s;
    logic [2:0]             agc_gain_s;
    logic [3:0]             agc_quiet_s;
    logic [3:0]             quiet_inc_s;

    // Window accumulation, EVAL sequencing and the gain decision.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_peak_d   = run_peak_q;
        run_clip_d   = run_clip_q;
        snap_peak_d  = snap_peak_q;
        snap_clip_d  = snap_clip_q;
        peak_level_d = peak_level_q;
        clip_d       = clip_q;
        peak_valid_d = 1'b0;
        agc_gain_s   = gain_q;
        agc_quiet_s  = quiet_q;
        quiet_inc_s  = quiet_q + 4'd1;

        sample_abs_s = abs_sat(bus.audio_in);
        win_last_s   = (cnt_q == {WINDOW_LOG2{1'b1}});
        peak_merge_s = (sample_abs_s > run_peak_q) ? sample_abs_s : run_peak_q;
        clip_merge_s = run_clip_q | (sample_abs_s == 16'h7FFF);

        // The closing sample is folded into the snapshot, so it belongs to
        // the window it completes; samples in EVAL start the next window.
        if (bus.sample_valid) begin
            if (win_last_s) begin
                snap_peak_d = peak_merge_s;
                snap_clip_d = clip_merge_s;
                run_peak_d  = 16'h0000;
                run_clip_d  = 1'b0;
                cnt_d       = CNT_ZERO;
            end else begin
                run_peak_d  = peak_merge_s;
                run_clip_d  = clip_merge_s;
                cnt_d       = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_MEASURE: begin
                if (bus.sample_valid && win_last_s) begin
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_MEASURE;
                end
            end
            ST_EVAL: begin
                state_d      = ST_MEASURE;
                peak_level_d = snap_peak_q;
                clip_d       = snap_clip_q;
                peak_valid_d = 1'b1;
                if (snap_clip_q) begin
                    agc_gain_s  = (gain_q > 3'd1) ? (gain_q - 3'd2) : 3'd0;
                    agc_quiet_s = 4'd0;
                end else if (snap_peak_q > HI_THRESH) begin
                    agc_gain_s  = (gain_q != 3'd0) ? (gain_q - 3'd1) : 3'd0;
                    agc_quiet_s = 4'd0;
                end else if (snap_peak_q < LO_THRESH) begin
                    if (quiet_inc_s >= HOLD_Q) begin
                        agc_gain_s  = (gain_q != 3'd7) ? (gain_q + 3'd1) : 3'd7;
                        agc_quiet_s = 4'd0;
                    end else begin
                        agc_quiet_s = quiet_inc_s;
                    end
                end else begin
                    agc_quiet_s = 4'd0;
                end
            end
            default: begin
                state_d = ST_MEASURE;
            end
        endcase

`ifdef AGC_MANUAL_OVERRIDE_EN
        // Manual code wins over any AGC step; the quiet streak restarts so
        // the loop resumes cleanly from the manual setting.
        if (manual_en) begin
            gain_d  = manual_code;
            quiet_d = 4'd0;
        end else begin
            gain_d  = agc_gain_s;
            quiet_d = agc_quiet_s;
        end
`else
        gain_d  = agc_gain_s;
        quiet_d = agc_quiet_s;
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_MEASURE;
            cnt_q        <= CNT_ZERO;
            run_peak_q   <= 16'h0000;
            run_clip_q   <= 1'b0;
            snap_peak_q  <= 16'h0000;
            snap_clip_q  <= 1'b0;
            quiet_q      <= 4'd0;
            gain_q       <= INIT_GAIN;
            peak_level_q <= 16'h0000;
            peak_valid_q <= 1'b0;
            clip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_peak_q   <= run_peak_d;
            run_clip_q   <= run_clip_d;
            snap_peak_q  <= snap_peak_d;
            snap_clip_q  <= snap_clip_d;
            quiet_q      <= quiet_d;
            gain_q       <= gain_d;
            peak_level_q <= peak_level_d;
            peak_valid_q <= peak_valid_d;
            clip_q       <= clip_d;
        end
    end

    assign bus.gain_code  = gain_q;
    assign bus.peak_level = peak_level_q;
    assign bus.peak_valid = peak_valid_q;
    assign bus.clip_flag  = clip_q;

endmodule

// File: tb/tb_audio_agc_level_ctrl.sv
// Testbench for audio_agc_level_ctrl (WINDOW_LOG2=4, HOLD_WINDOWS=2).
// Every cycle the outputs are compared with a reference model that collects
// each window's samples in a queue and applies the AGC rules arithmetically.
module tb_audio_agc_level_ctrl;

    localparam int WIN  = 16;
    localparam int HOLD = 2;
    localparam int HI   = 24576;   // 0x6000
    localparam int LO   = 8192;    // 0x2000

    logic clk;
    logic rst_n;
`ifdef AGC_MANUAL_OVERRIDE_EN
    logic       man_en;
    logic [2:0] man_code;
`endif

    audio_agc_level_ctrl_if bus ();

    audio_agc_level_ctrl #(
        .WINDOW_LOG2  (4),
        .HI_THRESH    (16'h6000),
        .LO_THRESH    (16'h2000),
        .HOLD_WINDOWS (2),
        .INIT_GAIN    (3'b100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef AGC_MANUAL_OVERRIDE_EN
        .manual_en   (man_en),
        .manual_code (man_code),
`endif
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int win_q[$];
    int exp_gain, exp_peak, exp_clip, exp_pv;
    int m_quiet;
    int due, pend_peak, pend_clip;
    int pv_seen;

    function automatic int abs_model(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        chk("gain_code",  {29'd0, bus.gain_code},  exp_gain);
        chk("peak_level", {16'd0, bus.peak_level}, exp_peak);
        chk("peak_valid", {31'd0, bus.peak_valid}, exp_pv);
        chk("clip_flag",  {31'd0, bus.clip_flag},  exp_clip);
    endtask

    task automatic model_reset();
        win_q.delete();
        exp_gain = 4; exp_peak = 0; exp_clip = 0; exp_pv = 0;
        m_quiet = 0; due = 0; pend_peak = 0; pend_clip = 0;
    endtask

    task automatic model_apply();
        exp_peak = pend_peak;
        exp_clip = pend_clip;
        exp_pv   = 1;
        if (pend_clip != 0) begin
            exp_gain = (exp_gain >= 2) ? exp_gain - 2 : 0;
            m_quiet  = 0;
        end else if (pend_peak > HI) begin
            exp_gain = (exp_gain >= 1) ? exp_gain - 1 : 0;
            m_quiet  = 0;
        end else if (pend_peak < LO) begin
            m_quiet++;
            if (m_quiet >= HOLD) begin
                exp_gain = (exp_gain < 7) ? exp_gain + 1 : 7;
                m_quiet  = 0;
            end
        end else begin
            m_quiet = 0;
        end
    endtask

    task automatic model_step(input logic v, input logic [15:0] x);
        int pk, cl;
        exp_pv = 0;
        if (due != 0) begin
            model_apply();
            due = 0;
        end
        if (v) begin
            win_q.push_back(abs_model(x));
            if (win_q.size() == WIN) begin
                pk = 0; cl = 0;
                foreach (win_q[i]) begin
                    if (win_q[i] > pk) pk = win_q[i];
                    if (win_q[i] == 32767) cl = 1;
                end
                win_q.delete();
                pend_peak = pk; pend_clip = cl; due = 1;
            end
        end
`ifdef AGC_MANUAL_OVERRIDE_EN
        if (man_en) begin
            exp_gain = int'(man_code);
            m_quiet  = 0;
        end
`endif
    endtask

    task automatic step(input logic v, input logic [15:0] x);
        @(negedge clk);
        bus.sample_valid = v;
        bus.audio_in     = x;
        @(posedge clk);
        #1;
        model_step(v, x);
        check_outputs();
        if (bus.peak_valid) pv_seen++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.sample_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        rst_n = 1'b1;
    endtask

    // One full window: sample at a random slot has magnitude lim (or is
    // -32768 when force_clip), the rest lim (all_max) or random 0..lim.
    task automatic send_window(input int lim, input bit all_max, input bit force_clip, input int gap_pct);
        int pos, n, mag;
        logic [15:0] s;
        pos = $urandom_range(0, WIN - 1);
        n = 0;
        while (n < WIN) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                step(1'b0, 16'($urandom));
            end else begin
                mag = (all_max || n == pos) ? lim : int'($urandom_range(0, lim));
                s = ($urandom_range(0, 1) == 1) ? 16'(-mag) : 16'(mag);
                if (force_clip && n == pos) s = 16'h8000;
                step(1'b1, s);
                n++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom));
    endtask

    initial begin
        int cat;
        rst_n = 1'b0;
        bus.sample_valid = 1'b0;
        bus.audio_in = 16'h0000;
        pv_seen = 0;
`ifdef AGC_MANUAL_OVERRIDE_EN
        man_en = 1'b0;
        man_code = 3'd0;
`endif
        model_reset();

        do_reset();
        idle(5);

        // two quiet windows: count 1, then increment
        send_window(32'h1000, 1'b1, 1'b0, 0);
        idle(3);
        send_window(32'h1000, 1'b1, 1'b0, 0);
        idle(3);

        // clipping windows drive gain down to floor
        for (int i = 0; i < 4; i++) begin
            send_window(32'h1000, 1'b0, 1'b1, 10);
            idle(3);
        end

        // quiet windows climb back up
        for (int i = 0; i < 6; i++) send_window(32'h1800, 1'b0, 1'b0, 5);
        idle(3);

        // threshold boundaries
        send_window(32'h6001, 1'b0, 1'b0, 0);
        idle(3);
        send_window(32'h6000, 1'b0, 1'b0, 0);
        idle(3);
        send_window(32'h2000, 1'b0, 1'b0, 0);
        idle(3);

        // quiet, mid, quiet: streak restarts
        send_window(32'h1FFF, 1'b0, 1'b0, 0);
        send_window(32'h3000, 1'b0, 1'b0, 0);
        send_window(32'h1FFF, 1'b0, 1'b0, 0);
        idle(3);

        // 48 back-to-back samples: exactly three report pulses
        pv_seen = 0;
        for (int i = 0; i < 3; i++) send_window(32'h4000, 1'b0, 1'b0, 0);
        idle(4);
        chk("pulse_count", 32'(pv_seen), 32'd3);

        // reset in mid-window discards the partial window
        for (int i = 0; i < 8; i++) step(1'b1, 16'h7000);
        do_reset();
        send_window(32'h1000, 1'b0, 1'b0, 0);
        idle(3);

        // ceiling at 7
        for (int i = 0; i < 16; i++) send_window(32'h0800, 1'b0, 1'b0, 20);
        idle(3);

        // randomized windows across all categories
        for (int i = 0; i < 30; i++) begin
            cat = $urandom_range(0, 3);
            case (cat)
                0: send_window($urandom_range(0, 32'h1FFF), 1'b0, 1'b0, 30);
                1: send_window($urandom_range(32'h2000, 32'h6000), 1'b0, 1'b0, 30);
                2: send_window($urandom_range(32'h6001, 32'h7FFE), 1'b0, 1'b0, 30);
                default: send_window($urandom_range(0, 32'h7FFF), 1'b0, 1'b1, 30);
            endcase
        end
        idle(3);

`ifdef AGC_MANUAL_OVERRIDE_EN
        // manual override holds the code while levels are still reported
        @(negedge clk);
        man_code = 3'b011;
        man_en   = 1'b1;
        step(1'b0, 16'h0000);
        send_window(32'h7000, 1'b0, 1'b0, 0);
        send_window(32'h1000, 1'b0, 1'b0, 0);
        send_window(32'h1000, 1'b0, 1'b0, 0);
        send_window(32'h1000, 1'b0, 1'b1, 0);
        idle(3);
        @(negedge clk);
        man_en = 1'b0;
        step(1'b0, 16'h0000);
        send_window(32'h1000, 1'b0, 1'b0, 0);
        send_window(32'h1000, 1'b0, 1'b0, 0);
        idle(3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
